// File: rtl/alarm_clock_pkg.sv
// Shared types and the two-digit BCD increment used by the time and alarm registers.
package alarm_clock_pkg;

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} alarm_state_t;

  typedef logic [7:0] bcd2_t;

  typedef struct packed {
    logic  carry;
    bcd2_t value;
  } bcd_inc_t;

  // Wraps to 00 with carry when value equals max (max given in BCD, e.g. 8'h59).
  function automatic bcd_inc_t bcd_inc(bcd2_t value, bcd2_t max);
    bcd_inc_t r;
    r.carry = 1'b0;
    if (value == max) begin
      r.value = '0;
      r.carry = 1'b1;
    end else if (value[3:0] == 4'd9) begin
      r.value = {value[7:4] + 4'd1, 4'd0};
    end else begin
      r.value = {value[7:4], value[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/alarm_clock_multi_channel.sv
// One alarm channel: hh:mm register, IDLE/RINGING/SNOOZED FSM, snooze countdown, ring timer.
module alarm_channel
  import alarm_clock_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        sec_edge,
  input  logic [23:0] time_next,
  input  logic        edit_min,
  input  logic        edit_hour,
  input  logic        arm,
  input  logic        snooze,
  input  logic        dismiss,
  output logic [15:0] alarm_hm,
  output logic        ringing,
  output logic        snoozed
);

  localparam int SNZ_LOAD = SNOOZE_MIN * 60;
  localparam int SW       = $clog2(SNZ_LOAD + 1);

  bcd2_t        hh, mm;
  bcd_inc_t     hh_i, mm_i;
  alarm_state_t state, state_nx;
  logic [SW-1:0] snz, snz_nx;
  logic [7:0]   ring_t, ring_nx;
  logic         match;

  assign hh_i     = bcd_inc(hh, 8'h23);
  assign mm_i     = bcd_inc(mm, 8'h59);
  assign match    = sec_edge && arm && (time_next == {hh, mm, 8'h00});
  assign alarm_hm = {hh, mm};
  assign ringing  = (state == RINGING);
  assign snoozed  = (state == SNOOZED);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      hh     <= '0;
      mm     <= '0;
      state  <= IDLE;
      snz    <= '0;
      ring_t <= '0;
    end else begin
      if (edit_min)  mm <= mm_i.value;
      if (edit_hour) hh <= hh_i.value;
      state  <= state_nx;
      snz    <= snz_nx;
      ring_t <= ring_nx;
    end
  end

  // Priority: disarm, dismiss, snooze, then match/timers.
  always_comb begin
    state_nx = state;
    snz_nx   = snz;
    ring_nx  = ring_t;
    case (state)
      IDLE: if (match) begin
        state_nx = RINGING;
        ring_nx  = '0;
      end
      RINGING: begin
        if (!arm || dismiss) state_nx = IDLE;
        else if (snooze) begin
          state_nx = SNOOZED;
          snz_nx   = SW'(SNZ_LOAD);
        end else if (sec_edge) begin
          if (ring_t == 8'(RING_SEC - 1)) state_nx = IDLE;
          else ring_nx = ring_t + 8'd1;
        end
      end
      SNOOZED: begin
        if (!arm || dismiss) state_nx = IDLE;
        else if (match) begin
          state_nx = RINGING;
          ring_nx  = '0;
        end else if (sec_edge) begin
          snz_nx = snz - SW'(1);
          if (snz == SW'(1)) begin
            state_nx = RINGING;
            ring_nx  = '0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/alarm_clock_multi.sv
// 24-hour BCD timekeeper with prescaler, time/alarm editing and ALARMS alarm channels.
module alarm_clock_multi
  import alarm_clock_pkg::*;
#(
  parameter int TICK_DIV   = 2500,
  parameter int ALARMS     = 2,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [2:0]        set_target,
  input  logic              inc_min,
  input  logic              inc_hour,
  input  logic [ALARMS-1:0] arm,
  input  logic              snooze,
  input  logic              dismiss,
  output logic [23:0]       time_bcd,
  output logic [15:0]       view_bcd,
  output logic [ALARMS-1:0] ringing,
  output logic [ALARMS-1:0] snoozed,
  output logic              tick,
  output logic              half_sec
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0] pre, pre_nx;
  bcd2_t         hh, mm, ss;
  bcd_inc_t      hh_i, mm_i, ss_i;
  logic          time_edit, sec_edge;
  logic [23:0]   time_next;
  logic [ALARMS-1:0][15:0] alarm_hm;

  assign time_bcd  = {hh, mm, ss};
  // An edit to the time swallows a coincident second boundary.
  assign time_edit = (set_target == 3'd0) && (inc_min || inc_hour);
  assign sec_edge  = (pre == PW'(TICK_DIV - 1)) && !time_edit;

  always_comb begin
    ss_i      = bcd_inc(ss, 8'h59);
    mm_i      = bcd_inc(mm, 8'h59);
    hh_i      = bcd_inc(hh, 8'h23);
    time_next = {hh, mm, ss_i.value};
    if (ss_i.carry) begin
      time_next[15:8] = mm_i.value;
      if (mm_i.carry) time_next[23:16] = hh_i.value;
    end
    if (time_edit || pre == PW'(TICK_DIV - 1)) pre_nx = '0;
    else pre_nx = pre + PW'(1);
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      pre      <= '0;
      hh       <= '0;
      mm       <= '0;
      ss       <= '0;
      tick     <= 1'b0;
      half_sec <= 1'b1;
    end else begin
      pre      <= pre_nx;
      tick     <= sec_edge;
      half_sec <= (pre_nx < PW'(TICK_DIV / 2));
      if (time_edit) begin
        if (inc_min)  mm <= mm_i.value;
        if (inc_hour) hh <= hh_i.value;
        ss <= '0;
      end else if (sec_edge) begin
        {hh, mm, ss} <= time_next;
      end
    end
  end

  for (genvar k = 0; k < ALARMS; k++) begin : g_ch
    logic sel;
    assign sel = (set_target == 3'(k + 1));
    alarm_channel #(
      .SNOOZE_MIN(SNOOZE_MIN),
      .RING_SEC  (RING_SEC)
    ) u_ch (
      .clk_in   (clk_in),
      .reset    (reset),
      .sec_edge (sec_edge),
      .time_next(time_next),
      .edit_min (sel && inc_min),
      .edit_hour(sel && inc_hour),
      .arm      (arm[k]),
      .snooze   (snooze),
      .dismiss  (dismiss),
      .alarm_hm (alarm_hm[k]),
      .ringing  (ringing[k]),
      .snoozed  (snoozed[k])
    );
  end

  always_comb begin
    view_bcd = {hh, mm};
    for (int k = 0; k < ALARMS; k++)
      if (set_target == 3'(k + 1)) view_bcd = alarm_hm[k];
  end

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Directed plus randomized bench; reference keeps time as seconds-of-day and alarms as minutes.
module tb_alarm_clock_multi;

  localparam int TD = 4;
  localparam int NA = 2;
  localparam int SM = 1;
  localparam int RS = 3;

  logic          clk_in = 1'b0;
  logic          reset;
  logic [2:0]    set_target;
  logic          inc_min, inc_hour, snooze, dismiss;
  logic [NA-1:0] arm;
  logic [23:0]   time_bcd;
  logic [15:0]   view_bcd;
  logic [NA-1:0] ringing, snoozed;
  logic          tick, half_sec;

  int checks = 0;
  int errors = 0;

  alarm_clock_multi #(
    .TICK_DIV(TD), .ALARMS(NA), .SNOOZE_MIN(SM), .RING_SEC(RS)
  ) dut (
    .clk_in(clk_in), .reset(reset), .set_target(set_target),
    .inc_min(inc_min), .inc_hour(inc_hour), .arm(arm),
    .snooze(snooze), .dismiss(dismiss), .time_bcd(time_bcd),
    .view_bcd(view_bcd), .ringing(ringing), .snoozed(snoozed),
    .tick(tick), .half_sec(half_sec)
  );

  always #5 clk_in = ~clk_in;

  // Reference model state: 0 idle, 1 ringing, 2 snoozed.
  int m_pre, m_tod;
  int m_al[NA];
  int m_st[NA];
  int m_rt[NA];
  int m_sc[NA];
  bit m_tick, m_half;

  function automatic void model_reset();
    m_pre = 0; m_tod = 0; m_tick = 0; m_half = 1;
    for (int c = 0; c < NA; c++) begin
      m_al[c] = 0; m_st[c] = 0; m_rt[c] = 0; m_sc[c] = 0;
    end
  endfunction

  function automatic void model_step(int tgt, bit im, bit ih, logic [NA-1:0] a, bit sn, bit dm);
    bit t_edit, bnd, match;
    int nt, h, m;
    t_edit = (tgt == 0) && (im || ih);
    bnd    = (m_pre == TD - 1) && !t_edit;
    nt     = (m_tod + 1) % 86400;
    for (int c = 0; c < NA; c++) begin
      match = bnd && a[c] && (nt == m_al[c] * 60);
      if (m_st[c] == 0) begin
        if (match) begin m_st[c] = 1; m_rt[c] = 0; end
      end else if (!a[c] || dm) begin
        m_st[c] = 0;
      end else if (m_st[c] == 1) begin
        if (sn) begin m_st[c] = 2; m_sc[c] = SM * 60; end
        else if (bnd) begin
          m_rt[c]++;
          if (m_rt[c] == RS) m_st[c] = 0;
        end
      end else begin
        if (match) begin m_st[c] = 1; m_rt[c] = 0; end
        else if (bnd) begin
          m_sc[c]--;
          if (m_sc[c] == 0) begin m_st[c] = 1; m_rt[c] = 0; end
        end
      end
      if (tgt == c + 1) begin
        h = m_al[c] / 60; m = m_al[c] % 60;
        if (im) m = (m + 1) % 60;
        if (ih) h = (h + 1) % 24;
        m_al[c] = h * 60 + m;
      end
    end
    if (t_edit) begin
      h = m_tod / 3600; m = (m_tod / 60) % 60;
      if (im) m = (m + 1) % 60;
      if (ih) h = (h + 1) % 24;
      m_tod = h * 3600 + m * 60;
      m_pre = 0;
    end else begin
      m_pre = (m_pre + 1) % TD;
      if (bnd) m_tod = nt;
    end
    m_tick = bnd;
    m_half = (m_pre < TD / 2);
  endfunction

  function automatic logic [7:0] b2(int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    logic [23:0] et;
    logic [15:0] ev;
    logic [NA-1:0] er, es;
    int t;
    et = {b2(m_tod / 3600), b2((m_tod / 60) % 60), b2(m_tod % 60)};
    ev = et[23:8];
    t  = int'(set_target);
    if (t >= 1 && t <= NA) ev = {b2(m_al[t-1] / 60), b2(m_al[t-1] % 60)};
    for (int c = 0; c < NA; c++) begin
      er[c] = (m_st[c] == 1);
      es[c] = (m_st[c] == 2);
    end
    chk("time_bcd", 32'(time_bcd), 32'(et));
    chk("view_bcd", 32'(view_bcd), 32'(ev));
    chk("ringing", 32'(ringing), 32'(er));
    chk("snoozed", 32'(snoozed), 32'(es));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("half_sec", 32'(half_sec), 32'(m_half));
  endtask

  task automatic step(input logic [2:0] t, input bit im, input bit ih, input bit sn, input bit dm);
    set_target = t; inc_min = im; inc_hour = ih; snooze = sn; dismiss = dm;
    @(posedge clk_in);
    model_step(int'(t), im, ih, arm, sn, dm);
    #1;
    compare_all();
    inc_min = 0; inc_hour = 0; snooze = 0; dismiss = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(set_target, 0, 0, 0, 0);
  endtask

  task automatic edit(input logic [2:0] t, input int mins, input int hours);
    for (int i = 0; i < hours; i++) step(t, 0, 1, 0, 0);
    for (int i = 0; i < mins; i++) step(t, 1, 0, 0, 0);
  endtask

  task automatic wait_ring(input int c, input int bound);
    for (int i = 0; i < bound && !ringing[c]; i++) idle(1);
    chk("wait_ring", 32'(ringing[c]), 32'd1);
  endtask

  initial begin
    set_target = 0; inc_min = 0; inc_hour = 0; snooze = 0; dismiss = 0; arm = '0;
    reset = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk_in) reset = 1'b1;

    // Rollover 23:59:59 -> 00:00:00
    edit(3'd0, 59, 23);
    idle(59 * TD);
    chk("pre_roll", 32'(time_bcd), 32'h235959);
    idle(TD - 1);
    idle(1);
    chk("roll_time", 32'(time_bcd), 32'h000000);
    chk("roll_tick", 32'(tick), 32'd1);

    // Edit landing on a second boundary wins; tick dropped
    edit(3'd0, 34, 12);
    idle(56 * TD + TD - 1);
    step(3'd0, 1, 0, 0, 0);
    chk("edit_time", 32'(time_bcd), 32'h123500);
    chk("edit_tick", 32'(tick), 32'd0);
    idle(TD);
    chk("restart_tick", 32'(tick), 32'd1);

    // Out-of-range target ignores edits
    step(3'd3, 1, 1, 0, 0);
    chk("tgt3_view", 32'(view_bcd), 32'h1235);

    // Alarm trigger and ring timeout
    edit(3'd1, 2, 0);
    chk("alarm1_view", 32'(view_bcd), 32'h0002);
    edit(3'd0, 26, 12);
    arm = 2'b01;
    idle(59 * TD + TD - 1);
    chk("pre_ring", 32'(ringing), 32'd0);
    idle(1);
    chk("ring_time", 32'(time_bcd), 32'h000200);
    chk("ring_rise", 32'(ringing), 32'b01);
    idle(RS * TD - 1);
    chk("ring_hold", 32'(ringing), 32'b01);
    idle(1);
    chk("ring_timeout", 32'(ringing), 32'b00);

    // Snooze cycle
    edit(3'd1, 1, 0);
    wait_ring(0, 400);
    step(set_target, 0, 0, 1, 0);
    chk("snz_state", 32'({ringing, snoozed}), 32'b0001);
    idle(SM * 60 * TD - 2);
    chk("snz_hold", 32'(snoozed), 32'b01);
    idle(1);
    chk("snz_expire", 32'(ringing), 32'b01);
    step(set_target, 0, 0, 0, 1);
    chk("dismiss", 32'({ringing, snoozed}), 32'b0000);

    // snooze+dismiss together, then disarm while snoozed
    edit(3'd1, 2, 0);
    wait_ring(0, 400);
    step(set_target, 0, 0, 1, 1);
    chk("snz_dis_prio", 32'({ringing, snoozed}), 32'b0000);
    edit(3'd1, 1, 0);
    wait_ring(0, 400);
    step(set_target, 0, 0, 1, 0);
    chk("snz_again", 32'(snoozed), 32'b01);
    arm = 2'b00;
    step(set_target, 0, 0, 0, 0);
    chk("disarm", 32'({ringing, snoozed}), 32'b0000);

    // Asynchronous reset mid-ring on channel 2
    arm = 2'b11;
    edit(3'd2, 7, 0);
    wait_ring(1, 400);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_ring", 32'(ringing), 32'd0);
    chk("rst_time", 32'(time_bcd), 32'h000000);
    @(negedge clk_in) reset = 1'b1;

    // Randomized phase
    edit(3'd1, 1, 0);
    edit(3'd2, 2, 0);
    for (int i = 0; i < 4000; i++) begin
      logic [2:0] t;
      t = set_target;
      if ($urandom_range(63) == 0) t = 3'($urandom_range(3));
      if ($urandom_range(299) == 0) arm = 2'($urandom_range(3));
      step(t, $urandom_range(39) == 0, $urandom_range(399) == 0,
           $urandom_range(23) == 0, $urandom_range(47) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_clock_multi.md
# alarm_clock_multi

Single-clock, fully synchronous 24-hour timekeeper with `ALARMS` independent alarm channels, plus snooze and ring auto-timeout. It is the next generation of the display-driven alarm clock. Ripple-clocked digit counters are replaced by one prescaler and clock-enabled BCD cascades. The block adds time/alarm setting and per-channel alarm state machines. It feeds the existing seven-segment multiplexer through BCD outputs.

## Interface
- `TICK_DIV`, 2500: `clk_in` cycles per second, ≥2.
- `ALARMS`, 2: number of alarm channels, 1–7.
- `SNOOZE_MIN`, 5: snooze length in minutes, 1–59.
- `RING_SEC`, 60: ringing auto-off after this many seconds, 1–255.
- `clk_in` in 1: the block's single clock.
- `reset` in 1: asynchronous, active-low. All state clears while low.
- `set_target` in 3: 0 selects time; k in 1..ALARMS selects alarm k. Larger values select nothing.
- `inc_min` in 1: one-cycle pulse that adds one minute to the target.
- `inc_hour` in 1: one-cycle pulse that adds one hour to the target.
- `arm` in ALARMS: level signal; bit k-1 enables channel k.
- `snooze` in 1: one-cycle pulse.
- `dismiss` in 1: one-cycle pulse.
- `time_bcd` out 24: {hh, mm, ss} as six BCD digits.
- `view_bcd` out 16: {hh, mm} of alarm k when set_target = k; otherwise {hh, mm} of the time.
- `ringing` out ALARMS: channel is in RINGING.
- `snoozed` out ALARMS: channel is in SNOOZED.
- `tick` out 1: one-cycle strobe, asserted in the cycle after each second boundary.
- `half_sec` out 1: high for the first TICK_DIV/2 cycles of each second (colon/DP blink).

## Operation
- Prescaler runs 0..TICK_DIV-1. At the edge where it equals TICK_DIV-1, it wraps to 0 and the time advances one second.
- Time cascade: ss 00..59 → mm 00..59 → hh 00..23. 23:59:59 wraps to 00:00:00.
- Time edit (set_target=0):
  - inc_min: mm+1, 59→00, no carry into hh.
  - inc_hour: hh+1, 23→00.
  - Either edit clears ss and the prescaler. An edit and a second boundary in the same cycle: the edit wins, the tick is dropped.
  - inc_min and inc_hour together: both apply.
- Alarm edit (set_target=k): same wrap rules on alarm k's hh:mm. Time is untouched. An edit never changes channel state.
- set_target > ALARMS: edits ignored.
- Match for channel k: a second boundary whose new time equals {alarm_k, 00}, with arm[k-1] high. Edits never produce a match.
- Channel FSM states: IDLE, RINGING, SNOOZED.
  - IDLE→RINGING on match. Ring timer loads 0.
  - RINGING→SNOOZED on snooze. Snooze counter loads SNOOZE_MIN·60.
  - RINGING→IDLE on dismiss, on the ring timer reaching RING_SEC (counted in seconds), or when arm drops.
  - SNOOZED: the snooze counter decrements on each second boundary. At 0 the channel goes to RINGING with the ring timer cleared.
  - SNOOZED→IDLE on dismiss or when arm drops.
  - SNOOZED→RINGING on a fresh match; the snooze counter is abandoned.
  - A match while RINGING is ignored; the ring timer is not restarted.
- snooze affects only RINGING channels. dismiss affects RINGING and SNOOZED channels.
- snooze and dismiss in the same cycle: dismiss wins.
- Disarm has priority over every transition.

## Timing
- Reset values:
  - time 00:00:00, all alarms 00:00, prescaler 0.
  - all channels IDLE, so ringing=0 and snoozed=0.
  - tick=0, half_sec=1.
- All outputs are registered except view_bcd, which is a mux of registers.
- tick, the new time_bcd, and any match-driven ringing rise together, one cycle after the boundary edge.
- inc pulses are visible one cycle after the pulse.
- snooze/dismiss/disarm take effect on the next edge, so ringing falls one cycle after the pulse.
- Ring timeout: ringing stays high for exactly RING_SEC second boundaries after the rise.

## Structure
- Package `alarm_clock_pkg`:
  - `alarm_state_t` enum {IDLE, RINGING, SNOOZED}.
  - `bcd2_t` (8-bit two-digit BCD).
  - function `bcd_inc(value, max)` returning the wrapped value and a carry.
- Sub-module `alarm_channel`: holds one alarm's hh:mm register, its FSM, snooze counter and ring timer.
  - Inputs: sec_edge, time_next, edit strobes, arm, snooze, dismiss.
  - Instantiated ALARMS times by generate.
- Top level: prescaler, time cascade, edit decode, view mux.

## Test plan
Bench uses TICK_DIV=4, ALARMS=2, SNOOZE_MIN=1, RING_SEC=3.
- Rollover: set time to 23:59:59, run 4 cycles → time_bcd=00:00:00 with tick high in the same cycle.
- Edit vs tick: inc_min in the prescaler=3 cycle at 12:34:56 → 12:35:00; no tick that cycle; prescaler restarts.
- Alarm trigger: alarm1=00:02, arm=01, run from 00:01:59 → ringing=01 rises with time 00:02:00. Ringing falls after 3 ticks. alarm2 stays IDLE.
- Snooze cycle: snooze while ringing → snoozed=01, ringing=00. After 60 ticks, ringing=01 again. dismiss → both 0.
- Priority and disarm: snooze and dismiss pulsed together while ringing → IDLE. Drop arm while SNOOZED → IDLE on the next edge.
- Reset mid-ring: assert reset low asynchronously → ringing=0 and time=00:00:00 immediately, without waiting for a clock edge.
